// File: rtl/core_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : core_mem_arbiter_pkg                                       |
// | Brief   : Shared types for the fetch/load-store memory arbiter       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package core_mem_arbiter_pkg;

   // Arbiter FSM states: idle, or which requester currently owns the bus.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_t;

   // Requester identity; also remembers who was served last for round-robin.
   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1 bit.
   function automatic int wdog_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : core_mem_arbiter_if                                        |
// | Brief   : Pipeline-side requests and Wishbone-side bus signals       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface core_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Fetch requester
   logic                  i_req;
   logic [ADDR_W-1:0]     i_addr;
   logic                  i_ack;
   logic                  i_err;
   logic [DATA_W-1:0]     i_rdata;
   // Load/store requester
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_sel;
   logic                  d_ack;
   logic                  d_err;
   logic [DATA_W-1:0]     d_rdata;
   // Wishbone classic bus
   logic                  cyc_o;
   logic                  stb_o;
   logic                  we_o;
   logic [ADDR_W-1:0]     adr_o;
   logic [DATA_W-1:0]     dat_o;
   logic [DATA_W/8-1:0]   sel_o;
   logic [DATA_W-1:0]     dat_i;
   logic                  ack_i;
   logic                  err_i;

   // Arbiter view
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_sel,
      input  dat_i, ack_i, err_i,
      output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
      output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
   );

   // Environment view: pipeline stages plus the bus slave
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_sel,
      output dat_i, ack_i, err_i,
      input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
      input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
   );
endinterface
`default_nettype wire

// File: rtl/core_mem_arbiter_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bus_watchdog                                               |
// | Brief   : Saturating cycle counter flagging a hung bus transfer      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bus_watchdog
   import core_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  clear,
   input  wire  run,
   output logic expired
);
   localparam int c_W = wdog_width(TIMEOUT);
   localparam logic [c_W-1:0] c_MAX  = c_W'(TIMEOUT);
   localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT - 1);
   localparam logic [c_W-1:0] c_ONE  = c_W'(1);

   logic [c_W-1:0] r_cnt;

   // Count cycles spent in a transfer; saturate so a stuck bus cannot wrap.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_cnt <= '0;
      end else if (run && (r_cnt != c_MAX)) begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   // Fires in the TIMEOUT-th bus cycle; TIMEOUT of zero disables it.
   assign expired = (TIMEOUT != 0) && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : core_mem_arbiter                                           |
// | Brief   : Round-robin share of one Wishbone port between fetch and   |
// |           load/store, with a watchdog ending hung transfers          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  wire              clk,
   input  wire              reset,
   core_mem_arbiter_if.slave bus
);
   localparam int c_SEL_W = DATA_W / 8;

   arb_state_t          r_state;
   owner_t              r_last_grant;
   logic                r_cyc;
   logic                r_we;
   logic [ADDR_W-1:0]   r_adr;
   logic [DATA_W-1:0]   r_dat;
   logic [c_SEL_W-1:0]  r_sel;

   logic w_busy;
   logic w_expired;
   logic w_bus_ack;
   logic w_bus_err;
   logic w_done;
   logic w_grant_fetch;
   logic w_grant_data;

   assign w_busy = (r_state != ARB_IDLE);

   // err_i beats ack_i; a timeout only matters when the slave stayed silent.
   assign w_bus_err = w_busy & (bus.err_i | (~bus.ack_i & w_expired));
   assign w_bus_ack = w_busy & bus.ack_i & ~bus.err_i;
   assign w_done    = w_bus_err | w_bus_ack;

   // On contention the requester not served last wins.
   assign w_grant_fetch = bus.i_req & (~bus.d_req | (r_last_grant == OWN_DATA));
   assign w_grant_data  = bus.d_req & ~w_grant_fetch;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_done | ~w_busy),
      .run     (w_busy),
      .expired (w_expired)
   );

   // Arbitration FSM with registered bus outputs captured at grant time.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ARB_IDLE;
         r_last_grant <= OWN_DATA;
         r_cyc        <= 1'b0;
         r_we         <= 1'b0;
         r_adr        <= '0;
         r_dat        <= '0;
         r_sel        <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_grant_fetch) begin
                  r_state <= ARB_FETCH;
                  r_cyc   <= 1'b1;
                  r_we    <= 1'b0;
                  r_adr   <= bus.i_addr;
                  r_dat   <= '0;
                  r_sel   <= '1;
               end else if (w_grant_data) begin
                  r_state <= ARB_DATA;
                  r_cyc   <= 1'b1;
                  r_we    <= bus.d_we;
                  r_adr   <= bus.d_addr;
                  r_dat   <= bus.d_wdata;
                  r_sel   <= bus.d_sel;
               end
            end
            ARB_FETCH, ARB_DATA: begin
               if (w_done) begin
                  r_state      <= ARB_IDLE;
                  r_cyc        <= 1'b0;
                  r_we         <= 1'b0;
                  r_last_grant <= (r_state == ARB_FETCH) ? OWN_FETCH : OWN_DATA;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_cyc   <= 1'b0;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cyc_o = r_cyc;
   assign bus.stb_o = r_cyc;
   assign bus.we_o  = r_we;
   assign bus.adr_o = r_adr;
   assign bus.dat_o = r_dat;
   assign bus.sel_o = r_sel;

   // Responses go only to the owner, and are dropped if it abandoned the request.
   assign bus.i_ack = w_bus_ack & (r_state == ARB_FETCH) & bus.i_req;
   assign bus.i_err = w_bus_err & (r_state == ARB_FETCH) & bus.i_req;
   assign bus.d_ack = w_bus_ack & (r_state == ARB_DATA)  & bus.d_req;
   assign bus.d_err = w_bus_err & (r_state == ARB_DATA)  & bus.d_req;

   assign bus.i_rdata = bus.dat_i;
   assign bus.d_rdata = bus.dat_i;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_core_mem_arbiter                                        |
// | Brief   : Directed bench with transaction-level reference model      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_core_mem_arbiter;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   core_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

   core_mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // One outstanding transfer at most: who owns it, what was captured, and
   // how many bus cycles it has been waiting.
   logic        m_valid = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_owner_d = 1'b0;
   logic        m_last_d  = 1'b1;
   int          m_cycles = 0;
   logic        m_we  = 1'b0;
   logic [31:0] m_adr = '0;
   logic [31:0] m_dat = '0;
   logic [3:0]  m_sel = '0;

   function automatic logic m_finishing();
      return m_busy && (u_if.err_i || u_if.ack_i || (m_cycles == TIMEOUT - 1));
   endfunction

   always @(posedge clk) begin
      m_valid <= 1'b1;
      if (reset) begin
         m_busy   <= 1'b0;
         m_last_d <= 1'b1;
         m_cycles <= 0;
      end else if (m_busy) begin
         if (m_finishing()) begin
            m_busy   <= 1'b0;
            m_last_d <= m_owner_d;
            m_cycles <= 0;
         end else begin
            m_cycles <= m_cycles + 1;
         end
      end else if (u_if.i_req || u_if.d_req) begin
         logic pick_d;
         pick_d = u_if.i_req && u_if.d_req ? !m_last_d : u_if.d_req;
         m_busy    <= 1'b1;
         m_owner_d <= pick_d;
         m_cycles  <= 0;
         m_we  <= pick_d ? u_if.d_we    : 1'b0;
         m_adr <= pick_d ? u_if.d_addr  : u_if.i_addr;
         m_dat <= pick_d ? u_if.d_wdata : 32'h0;
         m_sel <= pick_d ? u_if.d_sel   : 4'hF;
      end
   end

   // Compare every cycle, mid-cycle, against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         logic fin, is_err, is_ack;
         fin    = m_finishing();
         is_err = fin && (u_if.err_i || !u_if.ack_i);
         is_ack = fin && u_if.ack_i && !u_if.err_i;
         check("cyc_o", u_if.cyc_o, m_busy);
         check("stb_o", u_if.stb_o, m_busy);
         check("we_o",  u_if.we_o,  m_busy ? m_we : 1'b0);
         if (m_busy) begin
            check("adr_o", u_if.adr_o, m_adr);
            check("dat_o", u_if.dat_o, m_dat);
            check("sel_o", u_if.sel_o, m_sel);
         end
         check("i_ack", u_if.i_ack, is_ack && !m_owner_d && u_if.i_req);
         check("i_err", u_if.i_err, is_err && !m_owner_d && u_if.i_req);
         check("d_ack", u_if.d_ack, is_ack &&  m_owner_d && u_if.d_req);
         check("d_err", u_if.d_err, is_err &&  m_owner_d && u_if.d_req);
         check("i_rdata", u_if.i_rdata, u_if.dat_i);
         check("d_rdata", u_if.d_rdata, u_if.dat_i);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input string name);
      int n = 0;
      while (u_if.cyc_o !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      if (u_if.cyc_o !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: cyc_o never rose (got %0b expected 1)", name, u_if.cyc_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation hung");
   end

   initial begin
      logic [31:0] seen [4];
      int          n;

      u_if.i_req = 0; u_if.i_addr = '0;
      u_if.d_req = 0; u_if.d_we = 0; u_if.d_addr = '0; u_if.d_wdata = '0; u_if.d_sel = '0;
      u_if.dat_i = '0; u_if.ack_i = 0; u_if.err_i = 0;
      tick(); tick();
      reset = 0;
      check("rst_cyc", u_if.cyc_o, 1'b0);
      check("rst_adr", u_if.adr_o, 32'h0);
      check("rst_sel", u_if.sel_o, 4'h0);
      check("rst_dat", u_if.dat_o, 32'h0);

      // 1: fetch only, slave acks in the 2nd bus cycle
      u_if.i_req = 1; u_if.i_addr = 32'h100;
      tick();
      check("t1_cyc", u_if.cyc_o, 1'b1);
      check("t1_adr", u_if.adr_o, 32'h100);
      check("t1_we",  u_if.we_o, 1'b0);
      check("t1_sel", u_if.sel_o, 4'hF);
      tick();
      u_if.ack_i = 1; u_if.dat_i = 32'hCAFE0001;
      #1;
      check("t1_iack",  u_if.i_ack, 1'b1);
      check("t1_rdata", u_if.i_rdata, 32'hCAFE0001);
      check("t1_dack",  u_if.d_ack, 1'b0);
      tick();
      u_if.ack_i = 0; u_if.i_req = 0;
      #1;
      check("t1_idle", u_if.cyc_o, 1'b0);

      // 2: contention straight after reset -> fetch first, then the store
      reset = 1; tick(); reset = 0;
      u_if.i_req = 1; u_if.i_addr = 32'h200;
      u_if.d_req = 1; u_if.d_we = 1; u_if.d_addr = 32'h300;
      u_if.d_wdata = 32'hDEADBEEF; u_if.d_sel = 4'h3;
      tick();
      check("t2_first_adr", u_if.adr_o, 32'h200);
      check("t2_first_we",  u_if.we_o, 1'b0);
      u_if.ack_i = 1; #1;
      check("t2_iack", u_if.i_ack, 1'b1);
      check("t2_dack_none", u_if.d_ack, 1'b0);
      tick();
      u_if.ack_i = 0; u_if.i_req = 0;
      tick();
      check("t2_st_adr", u_if.adr_o, 32'h300);
      check("t2_st_we",  u_if.we_o, 1'b1);
      check("t2_st_dat", u_if.dat_o, 32'hDEADBEEF);
      check("t2_st_sel", u_if.sel_o, 4'h3);
      u_if.ack_i = 1; #1;
      check("t2_dack", u_if.d_ack, 1'b1);
      tick();
      u_if.ack_i = 0; u_if.d_req = 0;

      // 3: sustained contention, owners must alternate F,D,F,D
      u_if.i_req = 1; u_if.i_addr = 32'h400;
      u_if.d_req = 1; u_if.d_we = 0; u_if.d_addr = 32'h500; u_if.d_sel = 4'hF;
      for (int t = 0; t < 4; t++) begin
         wait_cyc("t3_wait");
         seen[t] = u_if.adr_o;
         u_if.ack_i = 1;
         tick();
         u_if.ack_i = 0;
      end
      u_if.i_req = 0; u_if.d_req = 0;
      check("t3_own0", seen[0], 32'h400);
      check("t3_own1", seen[1], 32'h500);
      check("t3_own2", seen[2], 32'h400);
      check("t3_own3", seen[3], 32'h500);
      tick();

      // 4: watchdog on a silent slave, then a late ack
      u_if.d_req = 1; u_if.d_we = 0; u_if.d_addr = 32'h600;
      wait_cyc("t4_wait");
      n = 1;
      while (!u_if.d_err && n < 20) begin
         tick();
         n++;
      end
      check("t4_err_cycle", n, 8);
      tick();
      u_if.d_req = 0; u_if.ack_i = 1; #1;
      check("t4_cyc_low", u_if.cyc_o, 1'b0);
      check("t4_late_ack", u_if.d_ack, 1'b0);
      tick();
      u_if.ack_i = 0;
      tick();

      // 5: err_i and ack_i together on a fetch
      u_if.i_req = 1; u_if.i_addr = 32'h700;
      wait_cyc("t5_wait");
      u_if.ack_i = 1; u_if.err_i = 1; #1;
      check("t5_ierr", u_if.i_err, 1'b1);
      check("t5_iack", u_if.i_ack, 1'b0);
      tick();
      u_if.ack_i = 0; u_if.err_i = 0; u_if.i_req = 0;
      tick();

      // 6: reset in the middle of a data transfer
      u_if.d_req = 1; u_if.d_we = 1; u_if.d_addr = 32'h800; u_if.d_wdata = 32'h12345678;
      wait_cyc("t6_wait");
      tick();
      reset = 1;
      tick();
      reset = 0; u_if.d_req = 0; u_if.ack_i = 1; #1;
      check("t6_cyc", u_if.cyc_o, 1'b0);
      check("t6_dack", u_if.d_ack, 1'b0);
      check("t6_derr", u_if.d_err, 1'b0);
      tick();
      u_if.ack_i = 0;
      u_if.i_req = 1; u_if.i_addr = 32'h900;
      u_if.d_req = 1; u_if.d_we = 0; u_if.d_addr = 32'hA00;
      tick();
      check("t6_fetch_wins", u_if.adr_o, 32'h900);
      u_if.ack_i = 1;
      tick();
      u_if.ack_i = 0; u_if.i_req = 0; u_if.d_req = 0;
      tick(); tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
